booth_divider: RTL and testbench
================================

// Module: booth_divider
// PURPOSE
//  Sequential signed radix-2 non-restoring divider; the inverse companion of the Booth multiplier.
//  Computes quotient and remainder of two two's-complement operands.
//  Uses the same go/over handshake as the multiplier so both share one system controller.
//  Split into an FSM controller and a datapath, with WIDTH iteration cycles per divide.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      system clock, all state on posedge
//  clr        in   1      asynchronous active-low reset
//  go         in   1      start request; level, held high until over is seen
//  dividend   in   WIDTH  signed dividend, sampled on start edge only
//  divisor    in   WIDTH  signed divisor, sampled on start edge only
//  quotient   out  WIDTH  signed quotient, truncated toward zero
//  remainder  out  WIDTH  signed remainder, sign follows dividend
//  busy       out  1      high from start edge until over rises
//  over       out  1      result valid; high in DONE
//  div0       out  1      divide-by-zero flag, valid while over=1
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE; quotient=0, remainder=0, busy=0, over=0, div0=0.
//   Reset mid-divide aborts immediately. No partial result is kept.
//  States: IDLE -> ITER -> FIX -> DONE -> IDLE; IDLE -> DONE on zero divisor.
//  IDLE, go=1 (start edge E0):
//   - Capture sd=dividend[MSB], sv=divisor[MSB].
//   - Load A=0 (WIDTH+1 bits), Q=|dividend|, M=|divisor| (unsigned WIDTH bits, so |-2^(W-1)| fits).
//   - Load cnt=WIDTH; busy=1.
//   - If divisor==0: go to DONE and register div0=1, quotient={WIDTH{1}}, remainder=dividend, busy=0.
//  ITER (one step per edge):
//   - {A,Q} <<= 1, then A = A - M if the old A>=0, else A = A + M.
//   - Q[0] = ~A_new[MSB]. cnt decrements.
//   - Exit to FIX on the edge where cnt goes 1->0.
//  FIX (1 edge):
//   - If A<0, A += M.
//   - quotient = (sd^sv) ? -Q : Q.
//   - remainder = sd ? -A[W-1:0] : A[W-1:0].
//   - div0=0; busy=0; go to DONE.
//  DONE: over=1. Stay while go=1. Go to IDLE on the first edge with go=0, and clear over there.
//  Latency: over rises WIDTH+1 edges after E0 (9 for WIDTH=8), or 1 edge after E0 for a zero divisor.
//  quotient/remainder update only at FIX, or at E0 for a zero divisor. They hold through DONE and
//   IDLE until the next result.
//  Overflow -2^(W-1)/-1 wraps: quotient=8'h80, remainder=0 (W=8). No flag.
//  go and operand changes during ITER/FIX are ignored.
//  go held high across DONE does not restart; a new divide needs go low for at least 1 edge.
//  All arithmetic is modulo 2^(WIDTH+1) on A and modulo 2^WIDTH on outputs.
// STRUCTURE
//  Package div_pkg holds:
//   - state encoding localparams S_IDLE, S_ITER, S_FIX, S_DONE;
//   - DIV_WIDTH_DEFAULT = 8;
//   - the CNT_W = $clog2(WIDTH+1) helper.
//  Sub-module booth_divider_datapath holds:
//   - A/Q/M registers, the add/sub unit, cnt, the sign registers and the output registers;
//   - control inputs load, step, fix, ld_zero;
//   - status outputs a_neg, cnt_last, m_zero.
//  The top holds the FSM and the busy/over/div0 decode only.
// TESTING
//  1. 100/7, go held -> over rises 9 edges after E0; quotient=14 (8'h0E), remainder=2, div0=0.
//  2. -100/7 -> quotient=8'hF2 (-14), remainder=8'hFE (-2). 100/-7 -> 8'hF2, 8'h02.
//     -100/-7 -> 8'h0E, 8'hFE.
//  3. -128/-1 -> quotient=8'h80, remainder=0. -128/1 -> 8'h80, 0. 0/5 -> 0, 0.
//     3/7 -> 0, 3. 127/127 -> 1, 0.
//  4. 5/0 -> over and div0 high 1 edge after E0; quotient=8'hFF, remainder=8'h05; busy never
//     high after that edge.
//  5. Drop clr low 4 edges into a divide -> over=busy=0 and outputs=0 immediately. Then a fresh
//     go with 100/7 gives the correct result.
//  6. Hold go high 20 edges past over -> exactly one result, over stays 1. Lower go -> IDLE next
//     edge, over=0. Change operands mid-ITER -> result uses the E0 values.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state encoding and sizing helper for booth_divider
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_divider_datapath.sv
// rtl/booth_divider_datapath.sv - A/Q/M registers, add/sub unit, counter, sign and result registers
module booth_divider_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             ld_zero,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             a_neg,
    output logic             cnt_last,
    output logic             m_zero
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic             sd;
    logic             sv;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_new;
    logic [WIDTH-1:0] r_mag;

    // Unsigned magnitude: |-2^(W-1)| = 2^(W-1) still fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign m_ext    = {1'b0, m};
    assign a_sh     = {a[WIDTH-1:0], q[WIDTH-1]};
    assign a_new    = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    assign r_mag    = a[WIDTH] ? (a[WIDTH-1:0] + m) : a[WIDTH-1:0];
    assign a_neg    = a[WIDTH];
    assign cnt_last = (cnt == CNT_W'(1));
    assign m_zero   = (divisor == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a         <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            sd        <= 1'b0;
            sv        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (load) begin
                a   <= '0;
                q   <= mag(dividend);
                m   <= mag(divisor);
                cnt <= CNT_W'(WIDTH);
                sd  <= dividend[WIDTH-1];
                sv  <= divisor[WIDTH-1];
            end
            if (ld_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
            if (step) begin
                a   <= a_new;
                q   <= {q[WIDTH-2:0], ~a_new[WIDTH]};
                cnt <= cnt - CNT_W'(1);
            end
            if (fix) begin
                quotient  <= (sd ^ sv) ? (~q + 1'b1) : q;
                remainder <= sd ? (~r_mag + 1'b1) : r_mag;
            end
        end
    end

endmodule

// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - signed non-restoring divider: go/over FSM plus datapath instance
module booth_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             over,
    output logic             div0
);

    div_state_t state;

    logic load;
    logic step;
    logic fix;
    logic ld_zero;
    logic a_neg;
    logic cnt_last;
    logic m_zero;

    assign load    = (state == S_IDLE) && go;
    assign ld_zero = load && m_zero;
    assign step    = (state == S_ITER);
    assign fix     = (state == S_FIX);

    booth_divider_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .clr       (clr),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .ld_zero   (ld_zero),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .a_neg     (a_neg),
        .cnt_last  (cnt_last),
        .m_zero    (m_zero)
    );

    // The final negative-remainder correction lives in the datapath's fix path,
    // so the controller only needs a_neg for observability of the last step.
    logic unused_a_neg;
    assign unused_a_neg = a_neg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            over  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (m_zero) begin
                            state <= S_DONE;
                            div0  <= 1'b1;
                            busy  <= 1'b0;
                            over  <= 1'b1;
                        end else begin
                            state <= S_ITER;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    if (cnt_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                    div0  <= 1'b0;
                    busy  <= 1'b0;
                    over  <= 1'b1;
                end
                S_DONE: begin
                    // Level go held high must not retrigger; wait for it to drop.
                    if (!go) begin
                        state <= S_IDLE;
                        over  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// tb/tb_booth_divider.sv - scoreboard bench for booth_divider
module tb_booth_divider;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       go = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       over;
    logic       div0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       d0;
    } exp_t;

    exp_t sb[$];

    booth_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .go        (go),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .over      (over),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_div(input logic [7:0] dd, input logic [7:0] dv, input int hold);
        exp_t e;
        int   a;
        int   b;
        int   qi;
        int   ri;
        int   n;
        logic seen;
        logic ok;

        if (dv == 8'h00) begin
            e.q  = 8'hFF;
            e.r  = dd;
            e.d0 = 1'b1;
        end else begin
            a    = int'($signed(dd));
            b    = int'($signed(dv));
            qi   = a / b;
            ri   = a % b;
            e.q  = qi[7:0];
            e.r  = ri[7:0];
            e.d0 = 1'b0;
        end
        sb.push_back(e);

        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        go       = 1'b1;
        @(posedge clk);
        #1;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);

        if (dv == 8'h00) begin
            chk("zero_over", 32'(over), 32'd1);
            chk("zero_busy", 32'(busy), 32'd0);
        end else begin
            chk("start_busy", 32'(busy), 32'd1);
            chk("start_over", 32'(over), 32'd0);
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                @(posedge clk);
                #1;
                n++;
                seen = over;
            end
            chk("latency", 32'(n), 32'd9);
        end

        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            ok = ok && over && !busy;
        end
        chk("hold_done", 32'(ok), 32'd1);

        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div0", 32'(div0), 32'(e.d0));
        end

        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        chk("over_clear", 32'(over), 32'd0);
        chk("q_held", 32'(quotient), 32'(e.q));
        chk("r_held", 32'(remainder), 32'(e.r));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_over", 32'(over), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        run_div(8'd100, 8'd7, 0);
        run_div(-8'sd100, 8'd7, 0);
        run_div(8'd100, -8'sd7, 0);
        run_div(-8'sd100, -8'sd7, 0);
        run_div(8'h80, 8'hFF, 0);
        run_div(8'h80, 8'd1, 0);
        run_div(8'd0, 8'd5, 0);
        run_div(8'd3, 8'd7, 0);
        run_div(8'd127, 8'd127, 0);
        run_div(8'd5, 8'd0, 3);

        // Abort a divide four edges in with an asynchronous reset.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        go       = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        chk("abort_over", 32'(over), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        @(negedge clk);
        go  = 1'b0;
        clr = 1'b1;

        run_div(8'd100, 8'd7, 0);
        run_div(8'd100, 8'd7, 20);

        for (int i = 0; i < 6; i++) begin
            run_div(8'($urandom), 8'($urandom_range(1, 255)), 0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
